// File: rtl/alu_defs.sv
// Shared opcode and FSM definitions for the pipelined ALU / multiply-divide unit.
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_defs;

  // Bit 3 clear keeps the legacy 3-bit single-cycle ALU codes unchanged.
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSV   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
// Latency: start edge, WIDTH iteration edges, then one FINISH cycle (done high).
// Backpressure: busy high from start until FINISH retires; abort returns to idle.
// Ports: start/is_div/is_signed/a/b sampled when idle; abort cancels BUSY/FINISH;
//        done is high during FINISH (when not aborting) with hi/lo holding the
//        sign-corrected product {hi,lo} or remainder/quotient.
module alu_iter_muldiv
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             div_r;
  logic             neg_q;
  logic             neg_r;

  // Magnitudes; |most-negative| is still representable as an unsigned value.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign abs_a = a_neg ? (~a + 1'b1) : a;
  assign abs_b = b_neg ? (~b + 1'b1) : b;

  // One multiply step: conditional add into the high half, then shift the
  // whole {acc_hi,acc_lo} right; the multiplier drains out of acc_lo.
  logic [WIDTH:0]   madd;
  // One divide step: shift the next dividend bit into the partial remainder.
  // The remainder is always below the divisor, so the trial difference fits
  // in WIDTH bits whenever it is kept.
  logic [WIDTH:0]   shrem;
  logic             ge;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign madd  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign shrem = {acc_hi, acc_lo[WIDTH-1]};
  assign ge    = shrem >= {1'b0, opb};
  assign trial = shrem[WIDTH-1:0] - opb;

  always_comb begin
    nxt_hi = '0;
    nxt_lo = '0;
    if (div_r) begin
      nxt_hi = ge ? trial : shrem[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = madd[WIDTH:1];
      nxt_lo = {madd[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied on the final magnitudes during FINISH.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + 1'b1;

  always_comb begin
    hi = '0;
    lo = '0;
    if (div_r) begin
      lo = neg_q ? (~acc_lo + 1'b1) : acc_lo;
      hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
    end else begin
      {hi, lo} = neg_q ? prod_neg : prod;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      div_r  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_BUSY;
            cnt    <= CW'(WIDTH);
            acc_hi <= '0;
            acc_lo <= abs_a;
            opb    <= abs_b;
            div_r  <= is_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end
        end
        S_BUSY: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu_pipe.sv
// ALU with registered single-cycle ops plus iterative mul/div into HI/LO.
// Latency: simple ops and divide-by-zero 1 edge; mul/div WIDTH+1 edges after accept.
// Backpressure: in_ready low while mul/div is in flight; in_valid then ignored.
// Ports: in_valid/in_ready handshake with op1/op2/control; abort cancels mul/div;
//        out_valid pulses with result, o_zf/o_ovf/o_dz; hi/lo hold last mul/div;
//        busy mirrors !in_ready.
module alu_mdu_pipe
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       control,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             o_zf,
  output logic             o_ovf,
  output logic             o_dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  logic             accept;
  logic             is_muldiv;
  logic             div_zero;
  logic             mdu_start;
  logic             mdu_busy;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_hi;
  logic [WIDTH-1:0] mdu_lo;

  assign accept    = in_valid && in_ready;
  assign is_muldiv = (control[3:2] == 2'b11);
  // control[1] selects divide within the mul/div group.
  assign div_zero  = is_muldiv && control[1] && (op2 == '0);
  assign mdu_start = accept && is_muldiv && !div_zero;

  assign in_ready = !mdu_busy;
  assign busy     = mdu_busy;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mdu_start),
    .abort    (abort),
    .is_div   (control[1]),
    .is_signed(control[0]),
    .a        (op1),
    .b        (op2),
    .busy     (mdu_busy),
    .done     (mdu_done),
    .hi       (mdu_hi),
    .lo       (mdu_lo)
  );

  // Single-cycle datapath.
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_zf;

  assign sum  = op1 + op2;
  assign diff = op1 - op2;
  assign sh   = op2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_XOR:  alu_res = op1 ^ op2;
      OP_NOR:  alu_res = ~(op1 | op2);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SUB: begin
        alu_res = diff;
        // Same rule as ADD with B inverted: overflow when A and ~B share a sign.
        alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLL:  alu_res = op1 << sh;
      OP_SRL:  alu_res = op1 >> sh;
      OP_SRA:  alu_res = $unsigned($signed(op1) >>> sh);
      default: alu_res = '0;
    endcase
  end

  // The reserved opcode reports all flags clear even though its result is 0.
  assign alu_zf = (alu_res == '0) && (control != OP_RSV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      o_zf      <= 1'b0;
      o_ovf     <= 1'b0;
      o_dz      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (mdu_done) begin
        hi        <= mdu_hi;
        lo        <= mdu_lo;
        result    <= mdu_lo;
        o_zf      <= (mdu_lo == '0);
        o_ovf     <= 1'b0;
        o_dz      <= 1'b0;
        out_valid <= 1'b1;
      end else if (accept && div_zero) begin
        hi        <= op1;
        lo        <= '1;
        result    <= '1;
        o_zf      <= 1'b0;
        o_ovf     <= 1'b0;
        o_dz      <= 1'b1;
        out_valid <= 1'b1;
      end else if (accept && !is_muldiv) begin
        result    <= alu_res;
        o_zf      <= alu_zf;
        o_ovf     <= alu_ovf;
        o_dz      <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Self-checking bench for alu_mdu_pipe: vector table, scoreboard, corner sequences.
// Latency: checked per transaction against accept edge.
// Backpressure: stimulus waits on in_ready with a bounded cycle budget.
module tb_alu_mdu_pipe;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [3:0]    control;
  logic          abort;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          o_zf;
  logic          o_ovf;
  logic          o_dz;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;

  alu_mdu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .control  (control),
    .abort    (abort),
    .out_valid(out_valid),
    .result   (result),
    .o_zf     (o_zf),
    .o_ovf    (o_ovf),
    .o_dz     (o_dz),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zf;
    logic         ovf;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zf;
    logic         ovf;
    logic         dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[23];
  logic [W-1:0] cur_hi;
  logic [W-1:0] cur_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Edges from the accept edge to the edge that raises out_valid.
  function automatic int exp_lat(input logic [3:0] c, input logic [W-1:0] b);
    if (c[3:2] == 2'b11 && !(c[1] && b == '0)) return W + 1;
    return 0;
  endfunction

  // Reference for mul/div using wide native arithmetic.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.lo = '0; e.zf = 1'b0; e.ovf = 1'b0; e.dz = 1'b0;
    e.acc = 0;
    e.lat = exp_lat(c, b);
    if (!c[1]) begin
      if (c[0]) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else      p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else if (!c[0]) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.lo = 32'h80000000;
      e.hi = '0;
    end else begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end
    e.res = e.lo;
    e.zf  = (e.lo == '0) && !e.dz;
    return e;
  endfunction

  // Waits for in_ready (bounded), issues one request; called at posedge+1.
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, input bit push);
    int w = 0;
    while (!in_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready still %b after %0d cycles, required 1", in_ready, w);
      return;
    end
    control = c; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    e.acc = cyc;
    if (push) sb.push_back(e);
    in_valid = 1'b0;
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid: got 1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("o_zf",   64'(o_zf),   64'(e.zf));
        chk("o_ovf",  64'(o_ovf),  64'(e.ovf));
        chk("o_dz",   64'(o_dz),   64'(e.dz));
        chk("hi",     64'(hi),     64'(e.hi));
        chk("lo",     64'(lo),     64'(e.lo));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  initial begin
    exp_t e;
    int lowcnt;
    int w;
    logic [3:0] rc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    //            ctrl     a             b             res           hi            lo            zf ovf dz
    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        32'h0,        0, 1, 0};
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        32'h0,        1, 0, 0};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        32'h0,        0, 0, 0};
    vecs[3]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        32'h0,        1, 0, 0};
    vecs[4]  = '{4'b1010, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0,        32'h0,        0, 0, 0};
    vecs[5]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        32'h0,        0, 0, 0};
    vecs[6]  = '{4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0,        32'h0,        0, 0, 0};
    vecs[7]  = '{4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0,        32'h0,        0, 0, 0};
    vecs[8]  = '{4'b0100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 0};
    vecs[9]  = '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h0,        32'h0,        0, 0, 0};
    vecs[10] = '{4'b1001, 32'h80000000, 32'h00000024, 32'h08000000, 32'h0,        32'h0,        0, 0, 0};
    vecs[11] = '{4'b1011, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0,        32'h0,        0, 0, 0};
    vecs[12] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        32'h0,        0, 1, 0};
    vecs[13] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        32'h0,        1, 0, 0};
    vecs[14] = '{4'b1101, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 0};
    vecs[15] = '{4'b1111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0};
    vecs[16] = '{4'b1110, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 0, 0, 1};
    vecs[17] = '{4'b1100, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 32'h00000000, 1, 0, 0};
    vecs[18] = '{4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 0};
    vecs[19] = '{4'b1111, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 0, 0, 0};
    vecs[20] = '{4'b1110, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 32'h0FFFFFFF, 0, 0, 0};
    vecs[21] = '{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0};
    vecs[22] = '{4'b0000, 32'h00000003, 32'h00000005, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; control = '0; abort = 1'b0;
    #7;
    chk("rst_result",    64'(result),    64'h0);
    chk("rst_hi",        64'(hi),        64'h0);
    chk("rst_lo",        64'(lo),        64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_flags",     64'({o_zf, o_ovf, o_dz}), 64'h0);
    chk("rst_busy",      64'(busy),      64'h0);
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: simple ops issue back-to-back, mul/div wait on in_ready.
    for (int i = 0; i < 23; i++) begin
      e.res = vecs[i].res; e.hi = vecs[i].hi; e.lo = vecs[i].lo;
      e.zf = vecs[i].zf; e.ovf = vecs[i].ovf; e.dz = vecs[i].dz;
      e.lat = exp_lat(vecs[i].ctrl, vecs[i].b); e.acc = 0;
      send(vecs[i].ctrl, vecs[i].a, vecs[i].b, e, 1'b1);
    end
    cur_hi = 32'hFFFFFFFE; cur_lo = 32'h00000001;

    // abort while idle must not disturb a simple op.
    abort = 1'b1;
    e = '{res: 32'd9, hi: cur_hi, lo: cur_lo, zf: 0, ovf: 0, dz: 0, lat: 0, acc: 0};
    send(4'b0010, 32'd4, 32'd5, e, 1'b1);
    abort = 1'b0;

    // MULT with in_ready low-time count and ignored requests while busy.
    e = model(4'b1101, 32'hFFFFFFFE, 32'h3);
    send(4'b1101, 32'hFFFFFFFE, 32'h3, e, 1'b1);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!in_ready) lowcnt++;
      in_valid = (i >= 2 && i < 8);
      control = 4'b0010; op1 = 32'(i); op2 = 32'h1111;
    end
    in_valid = 1'b0;
    chk("mult_in_ready_low_cycles", 64'(lowcnt), 64'(W + 1));
    @(posedge clk); #1;

    // Randomised mul/div against the wide-arithmetic model.
    for (int i = 0; i < 6; i++) begin
      rc = 4'b1100 | 4'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      e = model(rc, ra, rb);
      send(rc, ra, rb, e, 1'b1);
    end

    // MULTU then an aborted DIVU: HI/LO/result must survive the abort.
    e = model(4'b1100, 32'h10000, 32'h10000);
    send(4'b1100, 32'h10000, 32'h10000, e, 1'b1);
    send(4'b1110, 32'd100, 32'd3, e, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'h1);
    chk("abort_busy",     64'(busy),     64'h0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_hi",     64'(hi),     64'h1);
    chk("abort_lo",     64'(lo),     64'h0);
    chk("abort_result", 64'(result), 64'h0);
    chk("abort_zf",     64'(o_zf),   64'h1);

    // Asynchronous reset in the middle of a MULT.
    e = model(4'b1101, 32'd7, 32'd9);
    send(4'b1101, 32'd7, 32'd9, e, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_hi",        64'(hi),        64'h0);
    chk("arst_lo",        64'(lo),        64'h0);
    chk("arst_result",    64'(result),    64'h0);
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_flags",     64'({o_zf, o_ovf, o_dz}), 64'h0);
    chk("arst_busy",      64'(busy),      64'h0);
    chk("arst_in_ready",  64'(in_ready),  64'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = '{res: 32'd5, hi: 32'h0, lo: 32'h0, zf: 0, ovf: 0, dz: 0, lat: 0, acc: 0};
    send(4'b0010, 32'd2, 32'd3, e, 1'b1);

    // Drain the scoreboard with a bounded wait.
    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
